mem_word_seq: RTL and testbench
===============================

# mem_word_seq

Parametrised word-access controller over a single byte-wide RAM. A multi-byte word is read or written little-endian: lane i maps to byte address addr+i, wrapping modulo DEPTH. Lanes are transferred serially, one per cycle, under a req/busy/done handshake, with per-lane byte enables. It is the next generation of the two-bank 16-bit word memory, generalised in word width and depth. It sits between a simple bus master and the byte-addressed storage in the simulation modules.

## Interface
- ADDR_W, 6, byte address width; DEPTH = 2**ADDR_W bytes
- BYTES, 2, bytes per word (1..8); data width is 8*BYTES
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  start request, sampled only when accept is allowed
- we  in  1  1 = write, 0 = read; latched with req
- addr  in  ADDR_W  base byte address of lane 0; latched with req
- be  in  BYTES  per-lane enable; latched with req
- wdata  in  8*BYTES  write word, lane i = wdata[8i+7:8i]; latched with req
- busy  out  1  high while lanes are being transferred
- done  out  1  one-cycle completion pulse
- rdata  out  8*BYTES  read result, valid from done until the next accept

## Operation
- States: IDLE, XFER, DONE. Lane counter idx has width clog2(BYTES), minimum 1 bit.
- Accept: a rising edge with req=1 and state in {IDLE, DONE}.
  - Latches we, addr, be and wdata.
  - Sets idx=0, state=XFER.
  - When we=0, clears rdata to 0.
- req is ignored in XFER. Latched operands are not affected by input changes after accept.
- XFER: each edge processes lane idx at byte address (addr_l + idx) truncated to ADDR_W bits, so the address wraps.
  - Write with be_l[idx]=1: RAM[a] <= wdata_l lane idx.
  - Write with be_l[idx]=0: no RAM change.
  - Read with be_l[idx]=1: rdata lane idx <= RAM[a].
  - Read with be_l[idx]=0: lane stays 0.
  - idx increments. On the edge that processes lane BYTES-1, state becomes DONE.
- DONE: lasts one cycle. Goes to XFER on accept, otherwise to IDLE.
- be all zero: the transaction still takes the full duration and pulses done; there are no side effects.
- busy = (state==XFER). done = (state==DONE). Both are decoded from registered state, with no combinational path from inputs.
- A write is visible to any later read transaction. There is no read-during-write conflict, because only one lane is accessed per cycle.
- Reset (async, any time, including mid-XFER):
  - state=IDLE, idx=0, busy=0, done=0, rdata=0.
  - All RAM bytes are cleared to 0x00.
  - A partially completed transaction is discarded.

## Timing
- Accept at edge E0. Lane i is processed at edge E0+1+i.
- done is high during the cycle after edge E0+BYTES, i.e. BYTES cycles after accept. busy is high for exactly BYTES cycles.
- Back-to-back: with req held high, a new accept happens on the edge that leaves DONE. Throughput is one word per BYTES+1 cycles.
- rdata changes only at accept (cleared on reads) and at read-lane edges. It is stable from done until the next accept.
- Write data is in the RAM by the edge that processes its lane. Any lane read on a later edge sees it.

## Structure
- Shared package mem_pkg:
  - BYTE_W=8
  - state encoding constants ST_IDLE=2'd0, ST_XFER=2'd1, ST_DONE=2'd2
  - address-wrap helper function (base + offset truncated to ADDR_W)
- Sub-module byte_ram:
  - DEPTH x 8 bits, asynchronous active-low clear, synchronous write, combinational read.
  - Ports: clk, rst_n, we, addr, data, out.
  - The controller instantiates exactly one byte_ram.
- Controller: FSM, lane counter, operand latches, rdata register. Lane selection uses indexed part-select on idx.

## Test plan
- Reset, then read at addr=0x00 with be=2'b11 → done 2 cycles after accept, rdata=16'h0000. Also check busy=0, done=0, rdata=0 while rst_n=0.
- Write 16'hBEEF at addr=0x10, be=2'b11, then read the same address → RAM[0x10]=0xEF, RAM[0x11]=0xBE, rdata=16'hBEEF.
- Wrap: write 16'h1234 at addr=0x3F, then read addr=0x3F → rdata=16'h1234, RAM[0x3F]=0x34, RAM[0x00]=0x12.
- Byte enables:
  - Over 16'hBEEF at 0x10, write 16'h5566 with be=2'b10 → RAM holds 0xEF,0x55.
  - Read with be=2'b01 → rdata=16'h00EF.
  - Write with be=2'b00 → no RAM change, done still pulses.
- Handshake: req held high for 3 transactions → accepts at cycles 0, 3, 6. done pulses at 2, 5, 8. req asserted during busy is ignored and wdata changes during XFER have no effect.
- Reset mid-XFER after lane 0 of a write to 0x20 → immediate IDLE, outputs 0. A subsequent read of 0x20 returns 16'h0000.
- Parameter sweep: BYTES=4, ADDR_W=4 → write 32'hDEADBEEF at addr=0xE, then read it back → busy 4 cycles, rdata=32'hDEADBEEF, bytes stored at 0xE, 0xF, 0x0, 0x1.

Source files
------------

// File: rtl/mem_word_seq_pkg.sv
// Shared definitions for the serial word-access memory controller:
// byte width, FSM state encoding and the wrapping address helper.
package mem_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Byte address of a lane: base + offset, wrapped into an addr_w-bit space.
    function automatic logic [31:0] addr_wrap(input logic [31:0] base,
                                              input logic [31:0] offset,
                                              input int          addr_w);
        logic [31:0] mask_s;
        mask_s = (32'd1 << addr_w) - 32'd1;
        return (base + offset) & mask_s;
    endfunction

endpackage

// File: rtl/mem_word_seq_if.sv
// Request/response bundle between a bus master and mem_word_seq.
interface mem_word_seq_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int BYTES  = 2
);
    logic                      req;
    logic                      we;
    logic [ADDR_W-1:0]         addr;
    logic [BYTES-1:0]          be;
    logic [BYTE_W*BYTES-1:0]   wdata;
    logic                      busy;
    logic                      done;
    logic [BYTE_W*BYTES-1:0]   rdata;

    modport master (output req, output we, output addr, output be, output wdata,
                    input busy, input done, input rdata);
    modport slave  (input req, input we, input addr, input be, input wdata,
                    output busy, output done, output rdata);
endinterface

// File: rtl/mem_word_seq_byte_ram.sv
// DEPTH x 8 storage: asynchronous clear to zero, synchronous write,
// combinational read.
module byte_ram
    import mem_pkg::*;
#(
    parameter int ADDR_W = 6
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BYTE_W-1:0] data,
    output logic [BYTE_W-1:0] out
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [BYTE_W-1:0] mem_r [DEPTH];

    // Storage array: cleared on reset, one byte written per enabled edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (we) begin
            mem_r[addr] <= data;
        end
    end

    assign out = mem_r[addr];

endmodule

// File: rtl/mem_word_seq.sv
// Word-access controller: moves one little-endian lane per cycle between a
// latched request and a single byte-wide RAM, with per-lane enables.
module mem_word_seq
    import mem_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int BYTES  = 2
)(
    input  logic           clk,
    input  logic           rst_n,
    mem_word_seq_if.slave  bus
);
    localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int DATA_W = BYTE_W * BYTES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic [IDX_W-1:0]  idx_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [BYTES-1:0]  be_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;
    logic              busy_r;
    logic              done_r;

    logic              accept_s;
    logic              last_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [BYTE_W-1:0] ram_wdata_s;
    logic [BYTE_W-1:0] ram_rdata_s;

    assign accept_s    = bus.req && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign last_s      = (idx_r == LAST_IDX);
    assign ram_addr_s  = ADDR_W'(addr_wrap(32'(addr_r), 32'(idx_r), ADDR_W));
    assign ram_wdata_s = wdata_r[idx_r*BYTE_W +: BYTE_W];
    assign ram_we_s    = (state_r == ST_XFER) && we_r && be_r[idx_r];

    byte_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .data  (ram_wdata_s),
        .out   (ram_rdata_s)
    );

    // Next-state decode of the IDLE/XFER/DONE sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nx_s = ST_XFER;
                else          state_nx_s = ST_IDLE;
            end
            ST_XFER: begin
                if (last_s) state_nx_s = ST_DONE;
                else        state_nx_s = ST_XFER;
            end
            ST_DONE: begin
                if (accept_s) state_nx_s = ST_XFER;
                else          state_nx_s = ST_IDLE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM, operand latches, lane counter and read-data assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            idx_r   <= '0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            be_r    <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else begin
            state_r <= state_nx_s;
            // Flags track the next state so they sit in flops, aligned with state_r.
            busy_r  <= (state_nx_s == ST_XFER);
            done_r  <= (state_nx_s == ST_DONE);
            if (accept_s) begin
                we_r    <= bus.we;
                addr_r  <= bus.addr;
                be_r    <= bus.be;
                wdata_r <= bus.wdata;
                idx_r   <= '0;
                if (!bus.we) begin
                    rdata_r <= '0;
                end
            end else if (state_r == ST_XFER) begin
                idx_r <= idx_r + 1'b1;
                if (!we_r && be_r[idx_r]) begin
                    rdata_r[idx_r*BYTE_W +: BYTE_W] <= ram_rdata_s;
                end
            end
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_mem_word_seq.sv
// Self-checking bench for mem_word_seq: directed scenarios plus random traffic
// against a byte-array reference model, for two parameter sets.
module tb_mem_word_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_word_seq_if #(.ADDR_W(6), .BYTES(2)) if_a ();
    mem_word_seq_if #(.ADDR_W(4), .BYTES(4)) if_b ();

    mem_word_seq #(.ADDR_W(6), .BYTES(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    mem_word_seq #(.ADDR_W(4), .BYTES(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    logic [7:0] model_a [64];
    logic [7:0] model_b [16];

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model_a[i] = 8'h00;
        for (int i = 0; i < 16; i++) model_b[i] = 8'h00;
    endtask

    // Reference: each enabled lane i touches byte (addr+i) mod depth.
    task automatic model_a_txn(input logic we, input logic [5:0] addr, input logic [1:0] be,
                               input logic [15:0] wdata, output logic [15:0] rd);
        int a;
        rd = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            a = (int'(addr) + i) % 64;
            if (be[i] && we)  model_a[a] = wdata[8*i +: 8];
            if (be[i] && !we) rd[8*i +: 8] = model_a[a];
        end
    endtask

    task automatic model_b_txn(input logic we, input logic [3:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, output logic [31:0] rd);
        int a;
        rd = 32'h0;
        for (int i = 0; i < 4; i++) begin
            a = (int'(addr) + i) % 16;
            if (be[i] && we)  model_b[a] = wdata[8*i +: 8];
            if (be[i] && !we) rd[8*i +: 8] = model_b[a];
        end
    endtask

    // Issue one request on if_a; returns rdata at done, busy cycles and done latency.
    task automatic run_a(input logic we, input logic [5:0] addr, input logic [1:0] be,
                         input logic [15:0] wdata, output logic [15:0] rd,
                         output int busy_n, output int done_at);
        @(negedge clk);
        if_a.req = 1'b1; if_a.we = we; if_a.addr = addr; if_a.be = be; if_a.wdata = wdata;
        @(negedge clk);
        if_a.req = 1'b0;
        busy_n = 0; done_at = -1; rd = 16'h0;
        for (int k = 0; k < 16; k++) begin
            if (if_a.busy) busy_n++;
            if (if_a.done) begin done_at = k; rd = if_a.rdata; break; end
            if_a.wdata = 16'($urandom); if_a.addr = 6'($urandom); if_a.be = 2'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic run_b(input logic we, input logic [3:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, output logic [31:0] rd,
                         output int busy_n, output int done_at);
        @(negedge clk);
        if_b.req = 1'b1; if_b.we = we; if_b.addr = addr; if_b.be = be; if_b.wdata = wdata;
        @(negedge clk);
        if_b.req = 1'b0;
        busy_n = 0; done_at = -1; rd = 32'h0;
        for (int k = 0; k < 16; k++) begin
            if (if_b.busy) busy_n++;
            if (if_b.done) begin done_at = k; rd = if_b.rdata; break; end
            if_b.wdata = $urandom; if_b.addr = 4'($urandom); if_b.be = 4'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [15:0] rd; int bn; int da;
        rst_n = 1'b1;
        if_a.req = 1'b0; if_a.we = 1'b0; if_a.addr = 6'h00; if_a.be = 2'b00; if_a.wdata = 16'h0;
        if_b.req = 1'b0; if_b.we = 1'b0; if_b.addr = 4'h0; if_b.be = 4'h0; if_b.wdata = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", if_a.busy); end
        n_checks++; if (if_a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", if_a.done); end
        n_checks++; if (if_a.rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got %h expected 0000", if_a.rdata); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        run_a(1'b0, 6'h00, 2'b11, 16'h0, rd, bn, da);
        n_checks++; if (da !== 2) begin n_fail++; $display("FAIL first_read_latency got %0d expected 2", da); end
        n_checks++; if (bn !== 2) begin n_fail++; $display("FAIL first_read_busy got %0d expected 2", bn); end
        n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL first_read_rdata got %h expected 0000", rd); end
    endtask

    task automatic test_write_read();
        logic [15:0] rd; logic [15:0] mr; int bn; int da;
        run_a(1'b1, 6'h10, 2'b11, 16'hBEEF, rd, bn, da); model_a_txn(1'b1, 6'h10, 2'b11, 16'hBEEF, mr);
        n_checks++; if (da !== 2) begin n_fail++; $display("FAIL write_latency got %0d expected 2", da); end
        run_a(1'b0, 6'h10, 2'b11, 16'h0, rd, bn, da);
        n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL read_word got %h expected BEEF", rd); end
        run_a(1'b0, 6'h11, 2'b01, 16'h0, rd, bn, da);
        n_checks++; if (rd !== 16'h00BE) begin n_fail++; $display("FAIL read_byte_11 got %h expected 00BE", rd); end
    endtask

    task automatic test_wrap();
        logic [15:0] rd; logic [15:0] mr; int bn; int da;
        run_a(1'b1, 6'h3F, 2'b11, 16'h1234, rd, bn, da); model_a_txn(1'b1, 6'h3F, 2'b11, 16'h1234, mr);
        run_a(1'b0, 6'h3F, 2'b11, 16'h0, rd, bn, da);
        n_checks++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL wrap_word got %h expected 1234", rd); end
        run_a(1'b0, 6'h00, 2'b01, 16'h0, rd, bn, da);
        n_checks++; if (rd !== 16'h0012) begin n_fail++; $display("FAIL wrap_byte_00 got %h expected 0012", rd); end
        run_a(1'b0, 6'h3F, 2'b01, 16'h0, rd, bn, da);
        n_checks++; if (rd !== 16'h0034) begin n_fail++; $display("FAIL wrap_byte_3f got %h expected 0034", rd); end
    endtask

    task automatic test_byte_enables();
        logic [15:0] rd; logic [15:0] mr; int bn; int da;
        run_a(1'b1, 6'h10, 2'b10, 16'h5566, rd, bn, da); model_a_txn(1'b1, 6'h10, 2'b10, 16'h5566, mr);
        run_a(1'b0, 6'h10, 2'b11, 16'h0, rd, bn, da);
        n_checks++; if (rd !== 16'h55EF) begin n_fail++; $display("FAIL be10_word got %h expected 55EF", rd); end
        run_a(1'b0, 6'h10, 2'b01, 16'h0, rd, bn, da);
        n_checks++; if (rd !== 16'h00EF) begin n_fail++; $display("FAIL be01_read got %h expected 00EF", rd); end
        run_a(1'b1, 6'h10, 2'b00, 16'hFFFF, rd, bn, da);
        n_checks++; if (da !== 2) begin n_fail++; $display("FAIL be00_done got %0d expected 2", da); end
        n_checks++; if (bn !== 2) begin n_fail++; $display("FAIL be00_busy got %0d expected 2", bn); end
        run_a(1'b0, 6'h10, 2'b11, 16'h0, rd, bn, da);
        n_checks++; if (rd !== 16'h55EF) begin n_fail++; $display("FAIL be00_no_change got %h expected 55EF", rd); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d0; logic [15:0] d1; logic [15:0] rd8; logic [15:0] rd; logic [15:0] mr;
        int busy_n; int done_mask; int bn; int da;
        d0 = 16'($urandom); d1 = 16'($urandom); busy_n = 0; done_mask = 0; rd8 = 16'h0;
        @(negedge clk);
        if_a.req = 1'b1; if_a.we = 1'b1; if_a.addr = 6'h20; if_a.be = 2'b11; if_a.wdata = d0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (if_a.busy) busy_n++;
            if (if_a.done) done_mask = done_mask | (1 << k);
            if (k == 8) rd8 = if_a.rdata;
            if (k == 2) begin
                if_a.we = 1'b1; if_a.addr = 6'h22; if_a.be = 2'b11; if_a.wdata = d1;
            end else if (k == 5) begin
                if_a.we = 1'b0; if_a.addr = 6'h20; if_a.be = 2'b11; if_a.wdata = 16'($urandom);
            end else begin
                if (k >= 6) if_a.req = 1'b0;
                if_a.we = 1'($urandom); if_a.addr = 6'($urandom);
                if_a.be = 2'($urandom); if_a.wdata = 16'($urandom);
            end
        end
        model_a_txn(1'b1, 6'h20, 2'b11, d0, mr);
        model_a_txn(1'b1, 6'h22, 2'b11, d1, mr);
        n_checks++; if (done_mask !== 32'h124) begin n_fail++; $display("FAIL b2b_done_cycles got mask %h expected 124", done_mask); end
        n_checks++; if (busy_n !== 6) begin n_fail++; $display("FAIL b2b_busy got %0d expected 6", busy_n); end
        n_checks++; if (rd8 !== d0) begin n_fail++; $display("FAIL b2b_read got %h expected %h", rd8, d0); end
        run_a(1'b0, 6'h22, 2'b11, 16'h0, rd, bn, da);
        n_checks++; if (rd !== d1) begin n_fail++; $display("FAIL b2b_second_write got %h expected %h", rd, d1); end
    endtask

    task automatic test_reset_mid_xfer();
        logic [15:0] rd; int bn; int da;
        @(negedge clk);
        if_a.req = 1'b1; if_a.we = 1'b1; if_a.addr = 6'h20; if_a.be = 2'b11; if_a.wdata = 16'hA5C3;
        @(negedge clk);
        if_a.req = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (if_a.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b expected 1", if_a.busy); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b expected 0", if_a.busy); end
        n_checks++; if (if_a.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b expected 0", if_a.done); end
        n_checks++; if (if_a.rdata !== 16'h0) begin n_fail++; $display("FAIL midrst_rdata got %h expected 0000", if_a.rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        run_a(1'b0, 6'h20, 2'b11, 16'h0, rd, bn, da);
        n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL midrst_read20 got %h expected 0000", rd); end
        run_a(1'b0, 6'h10, 2'b11, 16'h0, rd, bn, da);
        n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL midrst_read10 got %h expected 0000", rd); end
    endtask

    task automatic test_random_a();
        logic we; logic [5:0] addr; logic [1:0] be; logic [15:0] wd;
        logic [15:0] rd; logic [15:0] mr; logic [15:0] exp_rd; int bn; int da;
        exp_rd = 16'h0;
        for (int t = 0; t < 40; t++) begin
            we = (t == 0) ? 1'b0 : 1'($urandom); addr = 6'($urandom);
            be = 2'($urandom); wd = 16'($urandom);
            run_a(we, addr, be, wd, rd, bn, da);
            model_a_txn(we, addr, be, wd, mr);
            if (!we) exp_rd = mr;
            n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rand_a_rdata t=%0d we=%b addr=%h be=%b got %h expected %h", t, we, addr, be, rd, exp_rd); end
            n_checks++; if (da !== 2 || bn !== 2) begin n_fail++; $display("FAIL rand_a_timing t=%0d got done=%0d busy=%0d expected 2/2", t, da, bn); end
        end
    endtask

    task automatic test_param_sweep();
        logic we; logic [3:0] addr; logic [3:0] be; logic [31:0] wd;
        logic [31:0] rd; logic [31:0] mr; int bn; int da;
        run_b(1'b1, 4'hE, 4'hF, 32'hDEADBEEF, rd, bn, da); model_b_txn(1'b1, 4'hE, 4'hF, 32'hDEADBEEF, mr);
        n_checks++; if (bn !== 4) begin n_fail++; $display("FAIL b4_write_busy got %0d expected 4", bn); end
        run_b(1'b0, 4'hE, 4'hF, 32'h0, rd, bn, da);
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b4_read got %h expected DEADBEEF", rd); end
        n_checks++; if (da !== 4) begin n_fail++; $display("FAIL b4_latency got %0d expected 4", da); end
        run_b(1'b0, 4'hF, 4'b0011, 32'h0, rd, bn, da);
        n_checks++; if (rd !== 32'h0000ADBE) begin n_fail++; $display("FAIL b4_wrap_bytes got %h expected 0000ADBE", rd); end
        run_b(1'b0, 4'h1, 4'b0001, 32'h0, rd, bn, da);
        n_checks++; if (rd !== 32'h000000DE) begin n_fail++; $display("FAIL b4_byte_01 got %h expected 000000DE", rd); end
        for (int t = 0; t < 16; t++) begin
            we = 1'($urandom); addr = 4'($urandom); be = 4'($urandom); wd = $urandom;
            run_b(we, addr, be, wd, rd, bn, da);
            model_b_txn(we, addr, be, wd, mr);
            if (!we) begin
                n_checks++; if (rd !== mr) begin n_fail++; $display("FAIL rand_b_rdata t=%0d addr=%h be=%b got %h expected %h", t, addr, be, rd, mr); end
            end
            n_checks++; if (da !== 4 || bn !== 4) begin n_fail++; $display("FAIL rand_b_timing t=%0d got done=%0d busy=%0d expected 4/4", t, da, bn); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_byte_enables();
        test_back_to_back();
        test_reset_mid_xfer();
        test_random_a();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
